// File: rtl/uart_tx_framer_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity-bit helper.
// Intended to be imported by both the transmit framer and the receiver.
package uart_tx_framer_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // data_xor is the XOR reduction of the data bits.
    function automatic logic parity_bit(input int mode, input logic data_xor);
        return (mode == PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-cycle tick every CLOCK_FREQ/BAUD clocks.
// clear restarts the count from 0 so a new bit period can be aligned to an event.
module uart_baud_tick #(
    parameter int CLOCK_FREQ = 16000000,
    parameter int BAUD       = 9600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CLK_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int CW          = $clog2(CLK_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// Byte-to-serial UART transmitter with valid/ready input, optional parity and
// gapless back-to-back frames (accept allowed in the final stop-bit cycle).
module uart_tx_framer
    import uart_tx_framer_pkg::*;
#(
    parameter int CLOCK_FREQ = 16000000,
    parameter int BAUD       = 9600,
    parameter int WIDTH      = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH) + 1;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    tx_state_e        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [BCW-1:0]   bit_cnt_q;
    logic             tx_q;
    logic             busy_q;
    logic             par_q;
    logic             tick;
    logic             stop_done;
    logic             accept;

    // Ready in IDLE and on the last cycle of the last stop bit, so a waiting byte starts with no gap.
    assign stop_done  = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
    assign data_ready = (state_q == ST_IDLE) || stop_done;
    assign accept     = data_valid && data_ready;
    assign shift_d    = shift_q >> 1;

    uart_baud_tick #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD       (BAUD)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            par_q     <= 1'b0;
        end else if (accept) begin
            state_q   <= ST_START;
            shift_q   <= data_in;
            par_q     <= parity_bit(PARITY, ^data_in);
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                ST_START: begin
                    if (tick) begin
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state_q   <= ST_STOP;
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
